gpr_scoreboard_file: RTL
========================

Name: gpr_scoreboard_file

Overview:
- Parametrised general-purpose register file, successor to the fixed 2-read/1-write GPR.
- Adds configurable data width, register count and read-port count.
- Adds optional write-to-read bypass and a per-register pending-write scoreboard so the decode stage can detect RAW hazards on in-flight writes.
- Sits between decode/issue (reads, issue marks) and writeback (writes, mark clears).

Parameters:
- XLEN, 32, data width of each register.
- NR_REG, 16, number of architectural registers (16 = RV32E, 32 = RV32I); index 0 is hard-wired zero.
- NR_READ, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle writeback is forwarded to reads and scoreboard outputs; 0 = registered view only.
- CNT_W, 2, width of each per-register pending-write counter (max outstanding writes per register = 2^CNT_W - 1).
- AW, 5, address width; must satisfy 2^AW >= NR_REG.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wen  in  1  writeback write enable.
- waddr  in  AW  writeback destination register.
- wdata  in  XLEN  writeback data.
- raddr  in  NR_READ*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NR_READ*XLEN  packed read data, combinational.
- rbusy  out  NR_READ  1 = register addressed by port i has a pending write.
- issue_valid  in  1  issue stage dispatches an instruction that will write issue_rd.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_ready  out  1  0 = issue_rd counter saturated; the issue must stall.
- sb_err  out  1  sticky error flag: writeback arrived for a register with zero pending count.

Behaviour:
- Reset (synchronous): all registers 1..NR_REG-1 = 0; all counters = 0; sb_err = 0. Outputs after reset: rdata = 0, rbusy = 0, issue_ready = 1.
- Register 0 and any address >= NR_REG behave identically:
  - read returns 0 with rbusy = 0;
  - write is ignored;
  - issue is ignored and does not set sb_err;
  - issue_ready = 1.
- Write: on posedge, if wen and waddr valid and nonzero, r[waddr] <= wdata. Data is always written, even if the counter is 0.
- Read data, combinational, per port:
  - BYPASS = 1 and wen and waddr == raddr_i (valid, nonzero): rdata_i = wdata.
  - Otherwise: rdata_i = r[raddr_i].
- Counter update, per register k (nonzero, valid), on posedge:
  - inc = issue_valid & issue_ready & (issue_rd == k).
  - dec = wen & (waddr == k) & (cnt[k] != 0).
  - inc & !dec: cnt + 1. dec & !inc: cnt - 1. Both or neither: unchanged.
  - Simultaneous issue and writeback to the same register keeps it busy.
- issue_ready:
  - 0 only when issue_valid, issue_rd valid and nonzero, and cnt[issue_rd] == 2^CNT_W - 1.
  - BYPASS = 1 and a same-cycle writeback to the same register frees a slot: issue_ready = 1.
- rbusy_i:
  - BYPASS = 0: (cnt[raddr_i] != 0).
  - BYPASS = 1: (cnt[raddr_i] != 0), except 0 when cnt == 1 and a same-cycle writeback targets raddr_i.
  - Issue in the current cycle never affects rbusy until the next cycle.
- sb_err: set on posedge when wen targets a valid nonzero register with cnt == 0. Stays set until reset.
- Reset asserted mid-operation: reset takes priority over all writes, issues and counter updates in that cycle.
- Latency: write-to-read is 1 cycle via the register array, 0 cycles with BYPASS. Scoreboard mark is visible 1 cycle after issue.

Test Plan:
1. Reset, then read all ports of x1..x15 -> rdata = 0, rbusy = 0, issue_ready = 1, sb_err = 0.
2. Write x5 = 0xDEADBEEF with raddr0 = 5 in the same cycle -> rdata0 = 0xDEADBEEF in that cycle when BYPASS = 1; old value 0 in that cycle and 0xDEADBEEF next cycle when BYPASS = 0.
3. Write x0 = 0x12345678, issue rd = 0, read x0 -> rdata = 0, rbusy = 0, sb_err = 0. Repeat with address 20 at NR_REG = 16 -> same result.
4. Issue rd = 3 three times with CNT_W = 2 -> cnt = 3, rbusy = 1. A 4th issue sees issue_ready = 0 and cnt stays 3. A 4th issue concurrent with a writeback to x3 sees issue_ready = 1 (BYPASS = 1) and cnt stays 3.
5. Issue rd = 7 once, then write x7 = 0xA5 -> rbusy for x7 is 0 in the writeback cycle (BYPASS = 1). Next cycle: cnt = 0, rdata = 0xA5.
6. Write x9 with cnt[9] = 0 -> x9 is updated, sb_err = 1 next cycle and stays 1. Assert reset -> sb_err = 0, x9 = 0.

Source files
------------

// File: rtl/gpr_scoreboard_file.sv
// Parametrised GPR file with optional write-to-read bypass and a per-register
// pending-write scoreboard used by decode to detect RAW hazards on in-flight writes.
module gpr_scoreboard_file #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NR_REG  = 16,
  parameter int unsigned NR_READ = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned AW      = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wen,
  input  logic [AW-1:0]           waddr,
  input  logic [XLEN-1:0]         wdata,
  input  logic [NR_READ*AW-1:0]   raddr,
  output logic [NR_READ*XLEN-1:0] rdata,
  output logic [NR_READ-1:0]      rbusy,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  output logic                    issue_ready,
  output logic                    sb_err
);

  localparam int unsigned      IW     = (NR_REG > 1) ? $clog2(NR_REG) : 1;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [XLEN-1:0]  r_regs [NR_REG];
  logic [CNT_W-1:0] r_cnt  [NR_REG];
  logic             r_sb_err;

  // x0 and out-of-range addresses are inert for every operation.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NR_REG);
  endfunction

  logic              w_wr_ok;
  logic [IW-1:0]     w_widx;
  logic              w_iss_ok;
  logic [IW-1:0]     w_iidx;
  logic              w_iss_wb;
  logic              w_inc_go;
  logic [NR_REG-1:0] w_inc;
  logic [NR_REG-1:0] w_dec;

  assign w_wr_ok  = wen && addr_ok(waddr);
  assign w_widx   = waddr[IW-1:0];
  assign w_iss_ok = issue_valid && addr_ok(issue_rd);
  assign w_iidx   = issue_rd[IW-1:0];
  assign w_iss_wb = (BYPASS != 0) && w_wr_ok && (waddr == issue_rd);

  // A retiring writeback to the same register frees a slot in the same cycle.
  assign issue_ready = !(w_iss_ok && (r_cnt[w_iidx] == CntMax) && !w_iss_wb);
  assign w_inc_go    = w_iss_ok && issue_ready;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_inc_go) w_inc[w_iidx] = 1'b1;
    if (w_wr_ok && (r_cnt[w_widx] != '0)) w_dec[w_widx] = 1'b1;
  end

  for (genvar g = 0; g < NR_READ; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [IW-1:0] w_ridx;
    logic          w_ok;
    logic          w_hit;

    assign w_ra   = raddr[g*AW +: AW];
    assign w_ridx = w_ra[IW-1:0];
    assign w_ok   = addr_ok(w_ra);
    assign w_hit  = (BYPASS != 0) && w_wr_ok && (waddr == w_ra);

    assign rdata[g*XLEN +: XLEN] = !w_ok ? '0 : (w_hit ? wdata : r_regs[w_ridx]);
    assign rbusy[g] = w_ok && (r_cnt[w_ridx] != '0) &&
                      !(w_hit && (r_cnt[w_ridx] == CNT_W'(1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NR_REG; k++) begin
        r_regs[k] <= '0;
        r_cnt[k]  <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_regs[w_widx] <= wdata;
        if (r_cnt[w_widx] == '0) r_sb_err <= 1'b1;
      end
      for (int k = 1; k < NR_REG; k++) begin
        if (w_inc[k] && !w_dec[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end else if (w_dec[k] && !w_inc[k]) begin
          r_cnt[k] <= r_cnt[k] - CNT_W'(1);
        end
      end
    end
  end

  assign sb_err = r_sb_err;

endmodule
